// File: rtl/tdm_demux_8.sv
// rtl/tdm_demux_8.sv - scanning 1-to-N_CH time-division demultiplexer with atomic frame commit
//
// Drives a channel address to an upstream N_CH:1 selector and samples its output
// one channel per slot. Samples build up in a shadow register, and q is updated
// from it in a single cycle once the frame is complete.
//
// Optional feature macro: TDM_PARITY_EN
//   When it is defined, channel N_CH-1 carries even parity over the other channels.
//   A frame with bad parity is not committed, and a one-cycle parity_err pulse is
//   raised instead.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   en           scan enable, sampled in IDLE and COMMIT
//   clr          synchronous clear of q/shadow; aborts the current frame
//   din          serial data from the upstream selector
//   sel          channel address presented to the selector
//   q            latched channel data, bit i = channel i
//   frame_valid  one-cycle pulse coincident with a q update
//   busy         high whenever the scanner is not IDLE
//   parity_err   (TDM_PARITY_EN only) one-cycle pulse on a rejected frame

module tdm_demux_8 #(
    parameter int N_CH = 8,
    parameter int AW   = 3,
    parameter int DIV  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic            din,
    output logic [AW-1:0]   sel,
    output logic [N_CH-1:0] q,
    output logic            frame_valid,
    output logic            busy
`ifdef TDM_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DIV - 1);
    localparam logic [AW-1:0] SEL_LAST   = AW'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   dwell;
    logic [N_CH-1:0] shadow;
    logic            slot_done;
    logic            parity_ok;
    logic            perr_r;

    assign slot_done = (dwell == DWELL_LAST);

`ifdef TDM_PARITY_EN
    assign parity_ok  = ~^shadow;
    assign parity_err = perr_r;
`else
    assign parity_ok  = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. clr takes priority over every other transition.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (en) state_nxt = SCAN;
                SCAN:    if (slot_done && sel == SEL_LAST) state_nxt = COMMIT;
                COMMIT:  state_nxt = en ? SCAN : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: address/dwell counters, shadow assembly, registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel         <= '0;
            dwell       <= '0;
            shadow      <= '0;
            q           <= '0;
            frame_valid <= 1'b0;
            perr_r      <= 1'b0;
        end else if (clr) begin
            sel         <= '0;
            dwell       <= '0;
            shadow      <= '0;
            q           <= '0;
            frame_valid <= 1'b0;
            perr_r      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            perr_r      <= 1'b0;
            case (state)
                IDLE: begin
                    sel   <= '0;
                    dwell <= '0;
                end
                SCAN: begin
                    if (slot_done) begin
                        // din is only sampled on the last dwell cycle, which
                        // gives the upstream selector time to settle after sel moves
                        shadow[sel] <= din;
                        dwell       <= '0;
                        // The last channel holds sel until COMMIT wraps it to 0
                        if (sel != SEL_LAST) begin
                            sel <= sel + 1'b1;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                COMMIT: begin
                    if (parity_ok) begin
                        q           <= shadow;
                        frame_valid <= 1'b1;
                    end else begin
                        perr_r <= 1'b1;
                    end
                    sel   <= '0;
                    dwell <= '0;
                end
                default: begin
                    sel   <= '0;
                    dwell <= '0;
                end
            endcase
        end
    end

`ifndef TDM_PARITY_EN
    logic unused_perr;
    assign unused_perr = perr_r;
`endif

endmodule

// File: tb/tb_tdm_demux_8.sv
// tb/tb_tdm_demux_8.sv - randomized self-checking bench for tdm_demux_8 (DIV=1 and DIV=4 instances)

module tb_tdm_demux_8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic clr = 1'b0;
    logic [7:0] d0 = 8'h00;
    logic [7:0] d1 = 8'h00;

    logic [2:0] sel0, sel1;
    logic [7:0] q0, q1;
    logic       fv0, fv1, busy0, busy1;
    logic       din0, din1;
`ifdef TDM_PARITY_EN
    logic       perr0, perr1;
`endif

    assign din0 = d0[sel0];
    assign din1 = d1[sel1];

    always #5 clk = ~clk;

    tdm_demux_8 #(.N_CH(8), .AW(3), .DIV(1)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din0),
        .sel(sel0), .q(q0), .frame_valid(fv0), .busy(busy0)
`ifdef TDM_PARITY_EN
        , .parity_err(perr0)
`endif
    );

    tdm_demux_8 #(.N_CH(8), .AW(3), .DIV(4)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din1),
        .sel(sel1), .q(q1), .frame_valid(fv1), .busy(busy1)
`ifdef TDM_PARITY_EN
        , .parity_err(perr1)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: pos = -1 idle, 0..8*div-1 scan slot position, 8*div commit
    int         m_pos [2];
    logic [7:0] m_sh  [2];
    logic [7:0] m_q   [2];
    logic       m_fv  [2];
    logic       m_pe  [2];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = -1; m_sh[i] = 8'h00; m_q[i] = 8'h00;
            m_fv[i] = 1'b0; m_pe[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i, input logic [7:0] d);
        int dv;
        bit ok;
        dv = div_of(i);
        m_fv[i] = 1'b0;
        m_pe[i] = 1'b0;
        if (clr) begin
            m_q[i] = 8'h00; m_sh[i] = 8'h00; m_pos[i] = -1;
        end else if (m_pos[i] == -1) begin
            if (en) m_pos[i] = 0;
        end else if (m_pos[i] < 8 * dv) begin
            if (m_pos[i] % dv == dv - 1) m_sh[i][m_pos[i] / dv] = d[m_pos[i] / dv];
            m_pos[i]++;
        end else begin
            ok = 1'b1;
`ifdef TDM_PARITY_EN
            ok = ($countones(m_sh[i]) % 2) == 0;
`endif
            if (ok) begin
                m_q[i] = m_sh[i]; m_fv[i] = 1'b1;
            end else begin
                m_pe[i] = 1'b1;
            end
            m_pos[i] = en ? 0 : -1;
        end
    endtask

    function automatic int exp_sel(input int i);
        if (m_pos[i] == -1) return 0;
        if (m_pos[i] >= 8 * div_of(i)) return 7;
        return m_pos[i] / div_of(i);
    endfunction

    task automatic check_all();
        check("q0",    32'(q0),    32'(m_q[0]));
        check("sel0",  32'(sel0),  32'(exp_sel(0)));
        check("fv0",   32'(fv0),   32'(m_fv[0]));
        check("busy0", 32'(busy0), 32'(m_pos[0] != -1));
        check("q1",    32'(q1),    32'(m_q[1]));
        check("sel1",  32'(sel1),  32'(exp_sel(1)));
        check("fv1",   32'(fv1),   32'(m_fv[1]));
        check("busy1", 32'(busy1), 32'(m_pos[1] != -1));
`ifdef TDM_PARITY_EN
        check("perr0", 32'(perr0), 32'(m_pe[0]));
        check("perr1", 32'(perr1), 32'(m_pe[1]));
`endif
    endtask

    // One clock: model consumes the inputs present before the edge, then outputs are checked
    task automatic step();
        logic [7:0] dd0, dd1;
        dd0 = d0;
        dd1 = d1;
        @(posedge clk);
        model_edge(0, dd0);
        model_edge(1, dd1);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_q0", 32'(q0), 32'h0);
        check("rst_busy0", 32'(busy0), 32'h0);
        check("rst_sel1", 32'(sel1), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single en pulse: DIV=1 commits at E+9, DIV=4 at E+33
        d0 = 8'hA5; d1 = 8'h81; en = 1'b1;
        step();
        en = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            step();
            if (k == 9) begin
                check("pulse_q0", 32'(q0), 32'hA5);
                check("pulse_fv0", 32'(fv0), 32'h1);
            end
            if (k == 10) check("pulse_idle0", 32'(busy0), 32'h0);
            if (k == 33) begin
                check("pulse_q1", 32'(q1), 32'h81);
                check("pulse_fv1", 32'(fv1), 32'h1);
            end
        end

        // Continuous en: DIV=1 frames every 9 cycles
        d0 = 8'h3C; en = 1'b1;
        step();
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 9) begin
                check("cont_q0a", 32'(q0), 32'h3C);
                d0 = 8'hC3;
            end
            if (k == 18) begin
                check("cont_q0b", 32'(q0), 32'hC3);
                check("cont_fv0b", 32'(fv0), 32'h1);
            end
        end

        // clr mid-frame: q cleared, no frame_valid
        while (sel0 != 3'd4) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_q0", 32'(q0), 32'h0);
        check("clr_busy0", 32'(busy0), 32'h0);
        en = 1'b0;
        for (int k = 0; k < 40; k++) step();

        // Randomized traffic with an asynchronous reset partway through
        for (int n = 0; n < 600; n++) begin
            en  = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) d0 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d1 = 8'($urandom);
            if (n == 300) begin
                #3;
                rst = 1'b1;
                #1;
                model_reset();
                check("arst_q1", 32'(q1), 32'h0);
                check("arst_sel1", 32'(sel1), 32'h0);
                check("arst_busy1", 32'(busy1), 32'h0);
                check("arst_fv0", 32'(fv0), 32'h0);
                #2;
                rst = 1'b0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
